// File: rtl/ex_div.sv
// Radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per cycle.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the long iteration.
module ex_div (
   input  logic        clk,
   input  logic        rst,
   input  logic        start_i,
   input  logic [2:0]  op_i,
   input  logic [31:0] dividend_i,
   input  logic [31:0] divisor_i,
   input  logic [4:0]  reg_waddr_i,
   input  logic        flush_i,
   output logic [31:0] result_o,
   output logic        ready_o,
   output logic        busy_o,
   output logic [4:0]  reg_waddr_o,
   output logic        reg_we_o
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_END} state_t;

   state_t      state_q, state_d;
   logic [31:0] dividend_q, dividend_d;
   logic [31:0] divisor_q, divisor_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] result_q, result_d;
   logic [4:0]  count_q, count_d;
   logic [4:0]  waddr_q, waddr_d;
   logic        is_rem_q, is_rem_d;
   logic        qsign_q, qsign_d;
   logic        rsign_q, rsign_d;

   logic        is_signed_in;
   logic        is_rem_in;
   logic [31:0] dividend_abs;
   logic [31:0] divisor_abs;
   logic [32:0] trial;
   logic [31:0] quot_fix;
   logic [31:0] rem_fix;
   logic [31:0] final_val;

   always_comb begin
      is_signed_in = (op_i == 3'b100) || (op_i == 3'b110);
      is_rem_in    = (op_i == 3'b110) || (op_i == 3'b111);
      dividend_abs = (is_signed_in && dividend_i[31]) ? (32'd0 - dividend_i) : dividend_i;
      divisor_abs  = (is_signed_in && divisor_i[31])  ? (32'd0 - divisor_i)  : divisor_i;

      // rem never has bit 31 set before the final step, so dropping it loses nothing
      trial = {1'b0, rem_q[30:0], dividend_q[count_q]} - {1'b0, divisor_q};

      quot_fix  = (qsign_q && (divisor_q != 32'd0)) ? (32'd0 - quot_q) : quot_q;
      rem_fix   = rsign_q ? (32'd0 - rem_q) : rem_q;
      final_val = is_rem_q ? rem_fix : quot_fix;

      state_d    = state_q;
      dividend_d = dividend_q;
      divisor_d  = divisor_q;
      rem_d      = rem_q;
      quot_d     = quot_q;
      result_d   = result_q;
      count_d    = count_q;
      waddr_d    = waddr_q;
      is_rem_d   = is_rem_q;
      qsign_d    = qsign_q;
      rsign_d    = rsign_q;

      case (state_q)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               dividend_d = dividend_abs;
               divisor_d  = divisor_abs;
               waddr_d    = reg_waddr_i;
               is_rem_d   = is_rem_in;
               qsign_d    = is_signed_in && (dividend_i[31] ^ divisor_i[31]);
               rsign_d    = is_signed_in && dividend_i[31];
               rem_d      = 32'd0;
               quot_d     = 32'd0;
               count_d    = 5'd31;
               state_d    = S_CALC;
`ifdef DIV_ZERO_FAST_EN
               // Preload so the single remaining step yields all-ones and the dividend
               if (divisor_abs == 32'd0) begin
                  rem_d   = dividend_abs >> 1;
                  quot_d  = 32'hFFFF_FFFF;
                  count_d = 5'd0;
               end
`endif
            end
         end
         S_CALC: begin
            if (!trial[32]) begin
               rem_d           = trial[31:0];
               quot_d[count_q] = 1'b1;
            end else begin
               rem_d           = {rem_q[30:0], dividend_q[count_q]};
               quot_d[count_q] = 1'b0;
            end
            count_d = count_q - 5'd1;
            if (count_q == 5'd0) begin
               state_d = S_END;
            end
         end
         S_END: begin
            result_d = final_val;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      if (flush_i) begin
         state_d  = S_IDLE;
         result_d = result_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= S_IDLE;
         dividend_q <= 32'd0;
         divisor_q  <= 32'd0;
         rem_q      <= 32'd0;
         quot_q     <= 32'd0;
         result_q   <= 32'd0;
         count_q    <= 5'd0;
         waddr_q    <= 5'd0;
         is_rem_q   <= 1'b0;
         qsign_q    <= 1'b0;
         rsign_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         dividend_q <= dividend_d;
         divisor_q  <= divisor_d;
         rem_q      <= rem_d;
         quot_q     <= quot_d;
         result_q   <= result_d;
         count_q    <= count_d;
         waddr_q    <= waddr_d;
         is_rem_q   <= is_rem_d;
         qsign_q    <= qsign_d;
         rsign_q    <= rsign_d;
      end
   end

   assign ready_o     = (state_q == S_END);
   assign busy_o      = (state_q != S_IDLE);
   assign reg_we_o    = ready_o;
   assign reg_waddr_o = waddr_q;
   assign result_o    = ready_o ? final_val : result_q;

endmodule
